// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: E-stage op encodings and sequencer states.
// Also used by the controller decoder and the hazard unit.
package mdu_ctrl_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_start_op(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E/D-stage request bundle and MDU result/status signals.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic [MD_OP_W-1:0] E_mdOp;
    logic [31:0]        E_rsVal;
    logic [31:0]        E_rtVal;
    logic               D_isMd;
    logic               start;
    logic               busy;
    logic               mdStall;
    logic [31:0]        HI;
    logic [31:0]        LO;
    logic [31:0]        E_mdRes;

    modport master (
        output E_mdOp, E_rsVal, E_rtVal, D_isMd,
        input  start, busy, mdStall, HI, LO, E_mdRes
    );

    modport slave (
        input  E_mdOp, E_rsVal, E_rtVal, D_isMd,
        output start, busy, mdStall, HI, LO, E_mdRes
    );

endinterface

// File: rtl/mdu_ctrl_md_calc.sv
// Combinational MDU datapath: 64-bit product, quotient/remainder.
// Divide by zero returns the current HI/LO so the registers hold.
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        rs,
    input  logic [31:0]        rt,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [31:0]        t_hi,
    output logic [31:0]        t_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] ub_safe;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign sgn     = (op == MD_DIV);
    assign a_neg   = sgn & rs[31];
    assign b_neg   = sgn & rt[31];
    assign ua      = a_neg ? -rs : rs;
    assign ub      = b_neg ? -rt : rt;
    assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    assign q       = ua / ub_safe;
    assign r       = ua % ub_safe;
    assign q_fix   = (a_neg ^ b_neg) ? -q : q;
    assign r_fix   = a_neg ? -r : r;

    always_comb begin
        t_hi = hi;
        t_lo = lo;
        case (op)
            MD_MULT: begin
                t_hi = prod_s[63:32];
                t_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                t_hi = prod_u[63:32];
                t_lo = prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (rt != 32'd0) begin
                    t_hi = r_fix;
                    t_lo = q_fix;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: latency counter, HI/LO ownership, stall request
// and mfhi/mflo read path for the E stage.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  md
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] thi_q, thi_d;
    logic [31:0] tlo_q, tlo_d;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        start;
    logic        busy;

    md_calc u_calc (
        .op   (md.E_mdOp),
        .rs   (md.E_rsVal),
        .rt   (md.E_rtVal),
        .hi   (hi_q),
        .lo   (lo_q),
        .t_hi (calc_hi),
        .t_lo (calc_lo)
    );

    assign busy  = (state_q == ST_BUSY);
    assign start = (state_q == ST_IDLE) && is_start_op(md.E_mdOp);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        thi_d   = thi_q;
        tlo_d   = tlo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thi_d   = calc_hi;
                    tlo_d   = calc_lo;
                    cnt_d   = (md.E_mdOp <= MD_MULTU) ? CW'(MULT_CYCLES)
                                                      : CW'(DIV_CYCLES);
                    state_d = ST_BUSY;
                end else if (md.E_mdOp == MD_MTHI) begin
                    hi_d = md.E_rsVal;
                end else if (md.E_mdOp == MD_MTLO) begin
                    lo_d = md.E_rsVal;
                end
            end
            ST_BUSY: begin
                // Any E-stage op here is ignored; the hazard unit forbids it.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = thi_q;
                    lo_d    = tlo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            thi_q   <= '0;
            tlo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            thi_q   <= thi_d;
            tlo_q   <= tlo_d;
        end
    end

    assign md.start   = start;
    assign md.busy    = busy;
    assign md.mdStall = md.D_isMd & (start | busy);
    assign md.HI      = hi_q;
    assign md.LO      = lo_q;
    assign md.E_mdRes = (md.E_mdOp == MD_MFHI) ? hi_q :
                        (md.E_mdOp == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus corner sequences.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mdu_ctrl_if md ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic        dmd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    vec_t vecs[8];
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        md.E_mdOp  = MD_NONE;
        md.E_rsVal = 32'd0;
        md.E_rtVal = 32'd0;
        md.D_isMd  = 1'b0;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        md.E_mdOp  = MD_MTHI;
        md.E_rsVal = h;
        tick();
        md.E_mdOp  = MD_MTLO;
        md.E_rsVal = l;
        tick();
        idle_in();
    endtask

    task automatic wait_idle(input logic dmd, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (md.busy === 1'b1 && n < 200) begin
            if (md.mdStall !== dmd) bad++;
            tick();
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int n;
        int bad;
        preload(v.pre_hi, v.pre_lo);
        md.E_mdOp  = v.op;
        md.E_rsVal = v.rs;
        md.E_rtVal = v.rt;
        md.D_isMd  = v.dmd;
        #1;
        chk({tag, " start"}, 32'(md.start), 32'd1);
        chk({tag, " stall0"}, 32'(md.mdStall), 32'(v.dmd));
        sbq.push_back('{v.exp_hi, v.exp_lo, v.cyc});
        tick();
        md.E_mdOp  = MD_NONE;
        md.E_rsVal = 32'hDEAD_BEEF;
        md.E_rtVal = 32'hCAFE_F00D;
        wait_idle(v.dmd, n, bad);
        e = sbq.pop_front();
        chk({tag, " cycles"}, 32'(n), 32'(e.cyc));
        chk({tag, " stall"}, 32'(bad), 32'd0);
        chk({tag, " HI"}, md.HI, e.hi);
        chk({tag, " LO"}, md.LO, e.lo);
        chk({tag, " stall_end"}, 32'(md.mdStall), 32'd0);
        md.E_mdOp = MD_MFLO;
        #1;
        chk({tag, " mflo"}, md.E_mdRes, e.lo);
        md.E_mdOp = MD_MFHI;
        #1;
        chk({tag, " mfhi"}, md.E_mdRes, e.hi);
        idle_in();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3, 0, 0, 1'b0,
                    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 1'b0,
                    32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 1'b0,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{MD_DIVU,  32'hFFFFFFF9, 32'd2, 0, 0, 1'b0,
                    32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4] = '{MD_DIV,   32'd100, 32'd0, 32'h11, 32'h22, 1'b0,
                    32'h11, 32'h22, 10};
        vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 1'b0,
                    32'h0, 32'h80000000, 10};
        vecs[6] = '{MD_MULT,  32'd6, 32'd7, 32'h33, 32'h44, 1'b1,
                    32'h0, 32'd42, 5};
        vecs[7] = '{MD_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 1'b1,
                    32'h1, 32'hFFFFFFFD, 10};

        reset = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
        md.E_mdOp = MD_MFHI;
        #1;
        chk("rst HI", md.HI, 32'd0);
        chk("rst LO", md.LO, 32'd0);
        chk("rst busy", 32'(md.busy), 32'd0);
        chk("rst mfhi", md.E_mdRes, 32'd0);
        idle_in();
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // mtlo then op 9 must read zero and not disturb HI/LO
        preload(32'hAAAA0001, 32'hBBBB0002);
        md.E_mdOp = 4'd9;
        #1;
        chk("op9 res", md.E_mdRes, 32'd0);
        chk("op9 start", 32'(md.start), 32'd0);
        tick();
        chk("op9 HI", md.HI, 32'hAAAA0001);
        chk("op9 LO", md.LO, 32'hBBBB0002);
        idle_in();

        // Restart attempt during BUSY must be ignored
        md.E_mdOp  = MD_MULT;
        md.E_rsVal = 32'hFFFFFFFE;
        md.E_rtVal = 32'd3;
        tick();
        md.E_mdOp  = MD_NONE;
        tick();
        md.E_mdOp  = MD_MULT;
        md.E_rsVal = 32'd5;
        md.E_rtVal = 32'd7;
        #1;
        chk("inj start", 32'(md.start), 32'd0);
        tick();
        md.E_mdOp = MD_MFHI;
        #1;
        chk("inj mfhi old", md.E_mdRes, 32'hAAAA0001);
        tick();
        idle_in();
        wait_idle(1'b0, n, bad);
        chk("inj cycles", 32'(n + 3), 32'd5);
        chk("inj HI", md.HI, 32'hFFFFFFFF);
        chk("inj LO", md.LO, 32'hFFFFFFFA);
        tick();

        // Reset in busy cycle 3 discards the pending product
        preload(32'h11, 32'h22);
        md.E_mdOp  = MD_MULT;
        md.E_rsVal = 32'd6;
        md.E_rtVal = 32'd7;
        tick();
        idle_in();
        tick();
        tick();
        chk("mid busy", 32'(md.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid rst busy", 32'(md.busy), 32'd0);
        chk("mid rst HI", md.HI, 32'd0);
        chk("mid rst LO", md.LO, 32'd0);
        repeat (8) tick();
        chk("post rst HI", md.HI, 32'd0);
        chk("post rst LO", md.LO, 32'd0);
        chk("post rst busy", 32'(md.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
